// File: rtl/alu_exec_pkg.sv
// Shared definitions for the multi-cycle ALU execute unit: selection codes,
// FSM state encoding and shift-code classification.
package alu_exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_ADDI = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SUB  = 4'b1110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between the ID/EX register (master) and the
// execute unit (slave), with valid/ready on both sides.
interface alu_exec_if #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_sel;
    logic            shift_r;
    logic            shift_i;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  imm_shamt;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    modport master (
        output in_valid, alu_sel, shift_r, shift_i, op_a, op_b, imm_shamt, out_ready,
        input  in_ready, out_valid, result, zero, illegal, busy
    );

    modport slave (
        input  in_valid, alu_sel, shift_r, shift_i, op_a, op_b, imm_shamt, out_ready,
        output in_ready, out_valid, result, zero, illegal, busy
    );
endinterface

// File: rtl/alu_exec_comb.sv
// Single-cycle, purely combinational part of the ALU: add/sub, logic ops,
// compares and detection of undefined selection codes.
module alu_exec_comb
    import alu_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      code,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result  = '0;
        illegal = 1'b0;
        case (code)
            ALU_ADD, ALU_ADDI: result = a + b;
            ALU_SUB:           result = a - b;
            ALU_AND:           result = a & b;
            ALU_OR:            result = a | b;
            ALU_XOR:           result = a ^ b;
            ALU_SLT:           result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:          result = {{(XLEN-1){1'b0}}, a < b};
            // Shifts are defined codes but are produced by the shifter in the top.
            ALU_SLL, ALU_SRL, ALU_SRA: result = '0;
            default:           illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: one-cycle logic ops, iterative shifts over a
// valid/ready handshake. Define ALU_EXEC_BARREL_EN for single-cycle shifts.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] SPC = (SHW+1)'(SHIFT_PER_CYCLE);

`ifdef ALU_EXEC_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    state_t          state;
    logic [XLEN-1:0] work_q;
    logic [SHW-1:0]  amt_q;
    logic [3:0]      code_q;
    logic            fill_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            illegal_q;
    logic            out_valid_q;
    logic            busy_q;
    logic            in_ready_q;

    logic [XLEN-1:0] comb_result;
    logic            comb_illegal;
    logic [SHW-1:0]  shamt;
    logic            sel_shift;
    logic            go_shift;
    logic [XLEN-1:0] accept_result;
    logic [SHW:0]    step;
    logic [SHW-1:0]  rem_next;
    logic [XLEN-1:0] shifted;

    // SRA fill comes from the captured sign bit, not from the working register.
    function automatic logic [XLEN-1:0] shift_by(input logic [3:0]      code,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [SHW:0]    amt,
                                                 input logic            fill);
        logic [XLEN-1:0] srl;
        logic [XLEN-1:0] mask;
        srl  = a >> amt;
        mask = ~({XLEN{1'b1}} >> amt);
        case (code)
            ALU_SLL: return a << amt;
            ALU_SRA: return srl | (fill ? mask : '0);
            default: return srl;
        endcase
    endfunction

    alu_exec_comb #(.XLEN(XLEN)) u_comb (
        .code    (bus.alu_sel),
        .a       (bus.op_a),
        .b       (bus.op_b),
        .result  (comb_result),
        .illegal (comb_illegal)
    );

    always_comb begin
        shamt     = bus.shift_i ? bus.imm_shamt : bus.op_b[SHW-1:0];
        sel_shift = is_shift(bus.alu_sel);
        go_shift  = sel_shift && !BARREL && (shamt != '0);
        if (!sel_shift)
            accept_result = comb_result;
        else if (BARREL)
            accept_result = shift_by(bus.alu_sel, bus.op_a, {1'b0, shamt}, bus.op_a[XLEN-1]);
        else
            accept_result = bus.op_a;

        step     = ({1'b0, amt_q} > SPC) ? SPC : {1'b0, amt_q};
        rem_next = amt_q - step[SHW-1:0];
        shifted  = shift_by(code_q, work_q, step, fill_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, including the datapath ones, is reset so an abandoned op leaves nothing behind.
        if (!rst_n) begin
            state       <= IDLE;
            work_q      <= '0;
            amt_q       <= '0;
            code_q      <= '0;
            fill_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here so all state updates see pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        illegal_q  <= comb_illegal;
                        if (go_shift) begin
                            state  <= SHIFT;
                            work_q <= bus.op_a;
                            amt_q  <= shamt;
                            code_q <= bus.alu_sel;
                            fill_q <= bus.op_a[XLEN-1];
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= accept_result;
                            zero_q      <= (accept_result == '0);
                        end
                    end
                end
                SHIFT: begin
                    work_q <= shifted;
                    amt_q  <= rem_next;
                    if (rem_next == '0) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= shifted;
                        zero_q      <= (shifted == '0);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Multi-cycle execute unit at the consuming end of the ALU-control interface. It takes the 4-bit ALU selection code and the shift_R/shift_I qualifiers produced by ALU control, together with the operands, and returns a result over a valid/ready handshake. Logic ops take one cycle; shifts iterate a fixed number of bits per cycle. Sits in the EX stage between the ID/EX register and the EX/MEM register.

Parameters:
XLEN, 32, datapath width
SHIFT_PER_CYCLE, 1, bits shifted per SHIFT-state cycle; power of two, 1..XLEN
SHW, $clog2(XLEN), shift-amount width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
alu_sel  in  4  ALU selection code
shift_r  in  1  shift amount comes from op_b[SHW-1:0]
shift_i  in  1  shift amount comes from imm_shamt
op_a  in  XLEN  operand A (rs1)
op_b  in  XLEN  operand B (rs2 or immediate)
imm_shamt  in  SHW  immediate shift amount
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
result  out  XLEN  result
zero  out  1  result == 0
illegal  out  1  alu_sel was not a defined code
busy  out  1  state != IDLE

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low. Reset forces state=IDLE and clears result, zero, illegal, out_valid, busy and all internal registers. in_ready=1 from reset release.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture all inputs.
    - Non-shift code, or shift with shamt 0 → DONE.
    - Shift with shamt>0 → SHIFT.
  - SHIFT: each cycle, shift the working register by min(SHIFT_PER_CYCLE, remaining) and decrement remaining. When remaining reaches 0 → DONE.
  - DONE: out_valid=1. result, zero and illegal are held stable until out_ready. On out_valid&&out_ready → IDLE.
  - in_ready=0 in SHIFT and DONE. There is no back-to-back accept; the next request is taken one cycle after the output handshake.
- Codes:
  - 0000 ADD, 1001 ADDI: op_a+op_b
  - 1110 SUB: op_a-op_b
  - 0001 AND
  - 0010 OR
  - 0011 XOR
  - 0110 SLT: signed compare, result 1 or 0
  - 0111 SLTU: unsigned compare, result 1 or 0
  - 0100 SLL, 0101 SRL, 1010 SRA
- Arithmetic wraps modulo 2^XLEN; no carry/overflow outputs.
- Shift amount: imm_shamt if shift_i=1, else op_b[SHW-1:0]; shift_i takes priority when both are set. Shift codes with both qualifiers low use op_b.
- SRA fill bit is the captured op_a[XLEN-1], sign-extending on every iteration.
- Latency, accept edge to out_valid high:
  - Non-shift: 1 cycle.
  - Shift: 1 + ceil(shamt/SHIFT_PER_CYCLE) cycles.
  - Shift with shamt 0: 1 cycle, result=op_a.
- Undefined code: 1-cycle path, result=0, zero=1, illegal=1.
- Inputs changing after capture have no effect.
- rst_n asserted mid-SHIFT or mid-DONE: the operation is abandoned and no out_valid is produced.

Optional Feature:
ALU_EXEC_BARREL_EN
- Defined: shifts use a combinational barrel shifter and take the 1-cycle path; the SHIFT state is unreachable and SHIFT_PER_CYCLE is ignored.
- Undefined: iterative shifting as described above.
- Results are identical either way; only latency differs.

Decomposition:
- Package alu_exec_pkg holds:
  - localparams for all ALU selection codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU, ALU_SRA, ALU_ADDI);
  - the state enum (IDLE, SHIFT, DONE);
  - a function is_shift(code).
- One sub-module: alu_exec_comb, the purely combinational non-shift ALU (add, sub, logic ops, compares, illegal detection).
- The FSM and shifter stay in the top module.

Test Plan:
- Reset release, then alu_sel=0000, op_a=5, op_b=7 → out_valid one cycle after accept; result=12, zero=0.
- alu_sel=1110, op_a=op_b=0x1234 → result=0, zero=1; out_ready held low 3 cycles → result stable and out_valid held until out_ready.
- alu_sel=1010, shift_i=1, imm_shamt=4, op_a=0x8000_0000, SHIFT_PER_CYCLE=1 → out_valid 5 cycles after accept; result=0xF800_0000.
- alu_sel=0100, shift_r=1, op_b=0xFFFF_FF03, op_a=1 → result=8 (only op_b[4:0] used); alu_sel=0110 with op_a=-1, op_b=1 → result=1; same operands with 0111 → result=0.
- alu_sel=1111 → illegal=1, result=0; alu_sel=0101 with shamt=0 → result=op_a in 1 cycle.
- rst_n asserted during SHIFT of a 31-bit SLL → out_valid never rises, in_ready=1 after release; repeat that shift with ALU_EXEC_BARREL_EN defined → same result with 1-cycle latency.
